// File: rtl/paper_feed_counter_if.sv
// ---------------------------------------------------------------------------
// paper_feed_counter_if: sensor/control inputs and event outputs of the feeder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface paper_feed_counter_if #(
  parameter int N = 1
);
  logic         sensor;
  logic         enable;
  logic         jam_clr;
  logic [N:0]   count;
  logic         status;
  logic         jam;
  logic         busy;

  modport master (
    output sensor,
    output enable,
    output jam_clr,
    input  count,
    input  status,
    input  jam,
    input  busy
  );

  modport slave (
    input  sensor,
    input  enable,
    input  jam_clr,
    output count,
    output status,
    output jam,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/paper_feed_counter.sv
// ---------------------------------------------------------------------------
// paper_feed_counter: synchronised, debounced sheet detector with jam/overflow
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module paper_feed_counter #(
  parameter int N           = 1,
  parameter int DEBOUNCE    = 4,
  parameter int JAM_CYCLES  = 64,
  parameter int LIMIT       = 4,
  parameter int STATUS_HOLD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  paper_feed_counter_if.slave  bus
);

  localparam int JW = $clog2(JAM_CYCLES);
  localparam int HW = (STATUS_HOLD < 2) ? 1 : $clog2(STATUS_HOLD + 1);

  localparam logic [7:0]    C_DEB_LAST  = 8'(DEBOUNCE - 1);
  localparam logic [7:0]    C_LIMIT     = 8'(LIMIT);
  localparam logic [JW-1:0] C_JAM_LAST  = JW'(JAM_CYCLES - 1);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(STATUS_HOLD);
  localparam logic [N:0]    C_EV_SHEET  = (N+1)'(1);
  localparam logic [N:0]    C_EV_JAM    = (N+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DB_HI   = 3'd1,
    S_PRESENT = 3'd2,
    S_DB_LO   = 3'd3,
    S_OVF     = 3'd4,
    S_JAM     = 3'd5
  } state_e;

  state_e          state_q;
  logic            sync1_q;
  logic            sync2_q;
  logic [7:0]      deb_q;
  logic [JW-1:0]   jcnt_q;
  logic [HW-1:0]   hold_q;
  logic [7:0]      tally_q;
  logic [N:0]      count_q;
  logic            status_q;
  logic            jam_q;
  logic            busy_q;
  logic            sensor_s;

  assign sensor_s = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      deb_q    <= '0;
      jcnt_q   <= '0;
      hold_q   <= '0;
      tally_q  <= '0;
      count_q  <= '0;
      status_q <= 1'b0;
      jam_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync1_q <= bus.sensor;
      sync2_q <= sync1_q;
      count_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (bus.enable && sensor_s) begin
            state_q <= S_DB_HI;
            deb_q   <= 8'd1;
            busy_q  <= 1'b1;
          end
        end

        S_DB_HI: begin
          if (!sensor_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (deb_q == C_DEB_LAST) begin
            state_q <= S_PRESENT;
            count_q <= C_EV_SHEET;
            jcnt_q  <= '0;
            // Saturate: a jammed final sheet can leave the tally at LIMIT.
            if (tally_q < C_LIMIT) begin
              tally_q <= tally_q + 8'd1;
            end
          end else begin
            deb_q <= deb_q + 8'd1;
          end
        end

        S_PRESENT: begin
          if (jcnt_q == C_JAM_LAST) begin
            state_q <= S_JAM;
            count_q <= C_EV_JAM;
            jam_q   <= 1'b1;
          end else begin
            jcnt_q <= jcnt_q + JW'(1);
            if (!sensor_s) begin
              state_q <= S_DB_LO;
              deb_q   <= 8'd1;
            end
          end
        end

        S_DB_LO: begin
          if (sensor_s) begin
            state_q <= S_PRESENT;
          end else if (deb_q == C_DEB_LAST) begin
            if (tally_q >= C_LIMIT) begin
              state_q  <= S_OVF;
              tally_q  <= '0;
              status_q <= 1'b1;
              hold_q   <= HW'(1);
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            deb_q <= deb_q + 8'd1;
          end
        end

        S_OVF: begin
          if (hold_q == C_HOLD_LAST) begin
            state_q  <= S_IDLE;
            status_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end

        S_JAM: begin
          if (bus.jam_clr && !sensor_s) begin
            state_q <= S_IDLE;
            jam_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          status_q <= 1'b0;
          jam_q    <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count  = count_q;
  assign bus.status = status_q;
  assign bus.jam    = jam_q;
  assign bus.busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_paper_feed_counter.sv
// ---------------------------------------------------------------------------
// tb_paper_feed_counter: directed and random sheets against an event timeline
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_paper_feed_counter;

  localparam int N    = 1;
  localparam int D    = 4;
  localparam int JC   = 64;
  localparam int LIM  = 4;
  localparam int HOLD = 2;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  paper_feed_counter_if #(.N(N)) bus ();

  paper_feed_counter #(
    .N           (N),
    .DEBOUNCE    (D),
    .JAM_CYCLES  (JC),
    .LIMIT       (LIM),
    .STATUS_HOLD (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected output per rising-edge index, filled from sheet timing rules.
  logic [N:0] exp_cnt  [MAXC];
  bit         exp_st   [MAXC];
  bit         exp_jam  [MAXC];
  bit         exp_busy [MAXC];

  int cyc;
  int n_checks;
  int n_fail;
  int tally;
  int k;
  int j;

  task automatic mark(input int which, input int a, input int b, input bit v);
    for (int i = a; i <= b && i < MAXC; i++) begin
      case (which)
        0:       exp_st[i]   = v;
        1:       exp_jam[i]  = v;
        default: exp_busy[i] = v;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d expected_below=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    n_checks++;
    assert (bus.count === exp_cnt[cyc]) else begin
      n_fail++;
      $error("FAIL count cyc=%0d observed=%0d expected=%0d", cyc, bus.count, exp_cnt[cyc]);
    end
    n_checks++;
    assert (bus.status === exp_st[cyc]) else begin
      n_fail++;
      $error("FAIL status cyc=%0d observed=%0b expected=%0b", cyc, bus.status, exp_st[cyc]);
    end
    n_checks++;
    assert (bus.jam === exp_jam[cyc]) else begin
      n_fail++;
      $error("FAIL jam cyc=%0d observed=%0b expected=%0b", cyc, bus.jam, exp_jam[cyc]);
    end
    n_checks++;
    assert (bus.busy === exp_busy[cyc]) else begin
      n_fail++;
      $error("FAIL busy cyc=%0d observed=%0b expected=%0b", cyc, bus.busy, exp_busy[cyc]);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = cyc + 1; i < MAXC; i++) begin
      exp_cnt[i]  = '0;
      exp_st[i]   = 1'b0;
      exp_jam[i]  = 1'b0;
      exp_busy[i] = 1'b0;
    end
    tally = 0;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // One sensor pulse w cycles wide. The sheet is accepted D+1 edges after the
  // first edge that samples it high, and ends D+1 edges after it goes low.
  task automatic sheet(input int w, input int gap, input bit drop_en, input int abort_lo);
    int ks;
    int x;
    ks = cyc + 1;
    bus.sensor = 1'b1;
    if (bus.enable) begin
      if (w >= D) begin
        exp_cnt[ks + 1 + D] = (N+1)'(1);
        if (tally < LIM) tally = tally + 1;
        x = ks + w + 1 + D;
        if (abort_lo > 0) begin
          mark(2, ks + 2, MAXC - 1, 1'b1);
        end else if (tally == LIM) begin
          mark(0, x, x + HOLD - 1, 1'b1);
          mark(2, ks + 2, x + HOLD - 1, 1'b1);
          tally = 0;
        end else begin
          mark(2, ks + 2, x - 1, 1'b1);
        end
      end else begin
        mark(2, ks + 2, ks + w + 1, 1'b1);
      end
    end
    for (int i = 0; i < w; i++) begin
      step();
      if (drop_en && i == D + 1) bus.enable = 1'b0;
    end
    bus.sensor = 1'b0;
    if (abort_lo > 0) repeat (abort_lo) step();
    else              repeat (gap) step();
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      exp_cnt[i]  = '0;
      exp_st[i]   = 1'b0;
      exp_jam[i]  = 1'b0;
      exp_busy[i] = 1'b0;
    end
    cyc         = 0;
    n_checks    = 0;
    n_fail      = 0;
    tally       = 0;
    rst         = 1'b1;
    bus.sensor  = 1'b0;
    bus.enable  = 1'b0;
    bus.jam_clr = 1'b0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    step();

    // Single clean sheet
    bus.enable = 1'b1;
    sheet(10, 12, 1'b0, 0);

    // Short glitch is rejected
    sheet(3, 10, 1'b0, 0);
    sheet(1, 10, 1'b0, 0);

    // Full batch, overflow, then a fresh sheet
    do_reset(1);
    sheet(8, 10, 1'b0, 0);
    sheet(5, 10, 1'b0, 0);
    sheet(12, 10, 1'b0, 0);
    sheet(4, 10, 1'b0, 0);
    sheet(9, 10, 1'b0, 0);

    // Jam: sheet held high for 100 cycles
    do_reset(1);
    k = cyc + 1;
    j = k + 1 + D + JC;
    bus.sensor = 1'b1;
    exp_cnt[k + 1 + D] = (N+1)'(1);
    exp_cnt[j]         = (N+1)'(2);
    tally = 1;
    mark(1, j, MAXC - 1, 1'b1);
    mark(2, k + 2, MAXC - 1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step();
      if (i == 80) bus.jam_clr = 1'b1;
      if (i == 85) bus.jam_clr = 1'b0;
    end
    bus.sensor = 1'b0;
    repeat (6) step();
    bus.jam_clr = 1'b1;
    mark(1, cyc + 1, MAXC - 1, 1'b0);
    mark(2, cyc + 1, MAXC - 1, 1'b0);
    step();
    bus.jam_clr = 1'b0;
    repeat (8) step();
    // Tally carried through the jam: three more sheets complete the batch
    sheet(6, 10, 1'b0, 0);
    sheet(7, 10, 1'b0, 0);
    sheet(6, 10, 1'b0, 0);

    // Reset during the trailing debounce of the third sheet
    do_reset(1);
    sheet(8, 10, 1'b0, 0);
    sheet(8, 10, 1'b0, 0);
    sheet(10, 0, 1'b0, 3);
    do_reset(1);
    repeat (4) sheet(7, 10, 1'b0, 0);

    // enable dropped mid-sheet, then a pulse with enable low
    sheet(12, 10, 1'b1, 0);
    sheet(10, 10, 1'b0, 0);
    bus.enable = 1'b1;

    // Random sheets, glitches and enable levels
    for (int r = 0; r < 30; r++) begin
      bus.enable = ($urandom_range(0, 4) != 0);
      sheet(int'($urandom_range(1, 30)), int'($urandom_range(D + HOLD + 2, 14)), 1'b0, 0);
    end
    bus.enable = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
